// File: rtl/game_sequencer_if.sv
// game_sequencer_if: frame/button/ball/brick inputs and the game-flow outputs
// exchanged between the game sequencer and its neighbours (VGA timing, ball
// logic, brick renderer). master = environment side, slave = sequencer side.
interface game_sequencer_if;
    logic        frame_pulse;
    logic        btn_action;
    logic        ball_lost;
    logic        brick_hit;
    logic        logic_frame_pulse;
    logic        logic_restart;
    logic        wall_reload;
    logic [2:0]  game_state;
    logic [2:0]  lives;
    logic [11:0] score;
    logic [3:0]  level;
    logic [5:0]  bricks_left;

    modport master (
        output frame_pulse,
        output btn_action,
        output ball_lost,
        output brick_hit,
        input  logic_frame_pulse,
        input  logic_restart,
        input  wall_reload,
        input  game_state,
        input  lives,
        input  score,
        input  level,
        input  bricks_left
    );

    modport slave (
        input  frame_pulse,
        input  btn_action,
        input  ball_lost,
        input  brick_hit,
        output logic_frame_pulse,
        output logic_restart,
        output wall_reload,
        output game_state,
        output lives,
        output score,
        output level,
        output bricks_left
    );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the breakout game. Sequences the
// ball/paddle logic through attract, serve, play, life-lost, level-clear and
// game-over, gates its frame pulse, and tracks lives/score/level/bricks.
// Optional feature macro: BONUS_LIFE_EN (extra life per 100 points).
//
// state   | meaning
// --------+---------------------------------------------------------
// ATTRACT | idle, waiting for the action button to start a game
// SERVE   | ball parked, counting SERVE_FRAMES before play resumes
// PLAY    | ball logic running; watches for wall clear / ball lost
// LOST    | life lost, pausing PAUSE_FRAMES before the next serve
// CLEAR   | wall cleared, pausing PAUSE_FRAMES before the next level
// OVER    | no lives left, score frozen until the button is pressed
module game_sequencer #(
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 7,
    parameter int BRICK_COUNT      = 40,
    parameter int SERVE_FRAMES     = 60,
    parameter int PAUSE_FRAMES     = 90,
    parameter int POINTS_PER_BRICK = 1
) (
    input logic             clk,
    input logic             nRst,
    game_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_SERVE   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_LOST    = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_OVER    = 3'd5
    } state_t;

    // Lives at game start never exceed the ceiling.
    localparam int START_EFF = (START_LIVES > MAX_LIVES) ? MAX_LIVES : START_LIVES;
    localparam int TMAX      = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
    localparam int TW        = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_SERVE     = TW'(SERVE_FRAMES);
    localparam logic [TW-1:0] T_PAUSE     = TW'(PAUSE_FRAMES);
    localparam logic [2:0]    LIVES_START = 3'(START_EFF);
    localparam logic [5:0]    BRICKS_FULL = 6'(BRICK_COUNT);
    localparam logic [12:0]   SCORE_STEP  = 13'(POINTS_PER_BRICK);
    localparam logic [12:0]   SCORE_MAX   = 13'd4095;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    lives_q;
    logic [11:0]   score_q;
    logic [3:0]    level_q;
    logic [5:0]    bricks_q;
    logic          restart_q;
    logic          reload_q;

    logic          hit_en;
    logic [12:0]   score_sum;
    logic [11:0]   score_hit;
    logic [5:0]    bricks_hit;
    logic [2:0]    lives_hit;
    logic [2:0]    lives_dec;
    logic [3:0]    level_next;
    logic          timer_last;

    // Next values for a brick hit, a lost ball, a level advance and the timer.
    always_comb begin
        hit_en     = bus.brick_hit && (state == ST_PLAY);
        score_sum  = {1'b0, score_q} + SCORE_STEP;
        score_hit  = (score_sum > SCORE_MAX) ? 12'hFFF : score_sum[11:0];
        bricks_hit = (bricks_q == 6'd0) ? 6'd0 : bricks_q - 6'd1;
        lives_hit  = lives_q;
`ifdef BONUS_LIFE_EN
        // One life per 100-point boundary crossed by this hit, capped.
        if (hit_en && ((score_q / 12'd100) != (score_hit / 12'd100))
            && (lives_q < 3'(MAX_LIVES)))
            lives_hit = lives_q + 3'd1;
`endif
        lives_dec  = (lives_hit == 3'd0) ? 3'd0 : lives_hit - 3'd1;
        level_next = (level_q == 4'd15) ? 4'd1 : level_q + 4'd1;
        // The timer holds the frames still to wait, counting the current one,
        // so the state moves on the frame that consumes the last count.
        timer_last = (timer <= TW'(1));
    end

    // Game-flow FSM with registered counters and one-clock restart/reload pulses.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state     <= ST_ATTRACT;
            timer     <= '0;
            lives_q   <= LIVES_START;
            score_q   <= 12'd0;
            level_q   <= 4'd1;
            bricks_q  <= BRICKS_FULL;
            restart_q <= 1'b0;
            reload_q  <= 1'b0;
        end else begin
            restart_q <= 1'b0;
            reload_q  <= 1'b0;

            if (hit_en) begin
                bricks_q <= bricks_hit;
                score_q  <= score_hit;
                lives_q  <= lives_hit;
            end

            case (state)
                ST_ATTRACT: begin
                    if (bus.frame_pulse && bus.btn_action) begin
                        lives_q   <= LIVES_START;
                        score_q   <= 12'd0;
                        level_q   <= 4'd1;
                        bricks_q  <= BRICKS_FULL;
                        restart_q <= 1'b1;
                        reload_q  <= 1'b1;
                        timer     <= T_SERVE;
                        state     <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (bus.frame_pulse) begin
                        if (timer_last) begin
                            timer <= '0;
                            state <= ST_PLAY;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    // Exit checks see the brick count from before this cycle's hit.
                    if (bus.frame_pulse) begin
                        if (bricks_q == 6'd0) begin
                            timer <= T_PAUSE;
                            state <= ST_CLEAR;
                        end else if (bus.ball_lost) begin
                            lives_q <= lives_dec;
                            if (lives_dec == 3'd0) begin
                                state <= ST_OVER;
                            end else begin
                                timer <= T_PAUSE;
                                state <= ST_LOST;
                            end
                        end
                    end
                end
                ST_LOST: begin
                    if (bus.frame_pulse) begin
                        if (timer_last) begin
                            restart_q <= 1'b1;
                            timer     <= T_SERVE;
                            state     <= ST_SERVE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    if (bus.frame_pulse) begin
                        if (timer_last) begin
                            level_q   <= level_next;
                            bricks_q  <= BRICKS_FULL;
                            restart_q <= 1'b1;
                            reload_q  <= 1'b1;
                            timer     <= T_SERVE;
                            state     <= ST_SERVE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                end
                ST_OVER: begin
                    if (bus.frame_pulse && bus.btn_action) begin
                        timer <= '0;
                        state <= ST_ATTRACT;
                    end
                end
                default: begin
                    // Unused codes fall back to attract without waiting for a frame.
                    timer <= '0;
                    state <= ST_ATTRACT;
                end
            endcase
        end
    end

    assign bus.logic_frame_pulse = bus.frame_pulse && (state == ST_PLAY);
    assign bus.logic_restart     = restart_q;
    assign bus.wall_reload       = reload_q;
    assign bus.game_state        = state;
    assign bus.lives             = lives_q;
    assign bus.score             = score_q;
    assign bus.level             = level_q;
    assign bus.bricks_left       = bricks_q;

endmodule
